keypad_pin_entry: RTL and testbench

//  Upstream stage of the parking access controller. Debounces a parking-entrance keypad and

---
 rtl/apac_pkg.sv | 21 ++
 rtl/key_debounce.sv | 67 ++++++
 rtl/keypad_pin_entry.sv | 215 +++++++++++++++++++++
 tb/tb_keypad_pin_entry.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/apac_pkg.sv
// Shared definitions for the parking access controller: key codes,
// keypad-entry FSM state encodings and PIN width derivation.
package apac_pkg;

    // Keypad codes: 4'h0-4'h9 are digits, these two are commands, the rest are ignored
    localparam logic [3:0] KEY_DIGIT_MAX = 4'h9;
    localparam logic [3:0] KEY_CLEAR     = 4'hA;
    localparam logic [3:0] KEY_ENTER     = 4'hB;

    // PIN entry FSM encodings
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_COLLECT = 2'd1;
    localparam logic [1:0] ST_READY   = 2'd2;
    localparam logic [1:0] ST_SUBMIT  = 2'd3;

    // One BCD nibble per digit
    function automatic int pin_width(input int num_digits);
        return 4 * num_digits;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Keypad front end: 2-FF synchroniser on the raw strobe, symmetric
// press/release debounce, and a single-cycle accept pulse with the
// captured key code.
module key_debounce
    import apac_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_press,
    input  logic [3:0] key_code_raw,
    output logic       key_accept,
    output logic [3:0] key_code
);

    localparam int              CNT_W    = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_r;
    logic             sync2_r;
    logic             level_r;
    logic             accept_r;
    logic [CNT_W-1:0] cnt_r;
    logic [3:0]       code_r;

    // Bring the asynchronous strobe into the clock domain
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
        end else begin
            sync1_r <= key_press;
            sync2_r <= sync1_r;
        end
    end

    // Flip the debounced level after DEBOUNCE_CYCLES consecutive disagreeing samples; any agreeing sample restarts the count
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            level_r  <= 1'b0;
            accept_r <= 1'b0;
            cnt_r    <= {CNT_W{1'b0}};
            code_r   <= 4'h0;
        end else begin
            accept_r <= 1'b0;
            if (sync2_r != level_r) begin
                if (cnt_r == CNT_LAST) begin
                    level_r  <= sync2_r;
                    cnt_r    <= {CNT_W{1'b0}};
                    accept_r <= sync2_r;
                    if (sync2_r) begin
                        code_r <= key_code_raw;
                    end
                end else begin
                    cnt_r <= cnt_r + CNT_W'(1);
                end
            end else begin
                cnt_r <= {CNT_W{1'b0}};
            end
        end
    end

    assign key_accept = accept_r;
    assign key_code   = code_r;

endmodule

// File: rtl/keypad_pin_entry.sv
// Keypad PIN entry stage: collects NUM_DIGITS BCD digits from the debounced
// keypad and hands a PIN attempt to the access controller on ENTER.
module keypad_pin_entry
    import apac_pkg::*;
#(
    parameter int  DEBOUNCE_CYCLES = 4,
    parameter int  TIMEOUT_CYCLES  = 64,
    parameter int  NUM_DIGITS      = 2,
    localparam int PIN_W           = pin_width(NUM_DIGITS)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             entry_en,
    input  logic             key_press,
    input  logic [3:0]       key_code,
    output logic [PIN_W-1:0] psswrd_atmpt,
    output logic             try_psswrd,
    output logic [2:0]       digit_count,
    output logic             entry_timeout,
    output logic             entry_error
);

    localparam int               TMO_W   = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [2:0]       DIG_MAX = 3'(NUM_DIGITS);

    logic             key_accept_s;
    logic [3:0]       key_code_s;

    logic [1:0]       state_r;
    logic [PIN_W-1:0] buf_r;
    logic [2:0]       cnt_r;
    logic [TMO_W-1:0] tmo_r;
    logic [PIN_W-1:0] atmpt_r;
    logic             try_r;
    logic             err_r;
    logic             tout_r;

    logic [1:0]       state_nx_s;
    logic [PIN_W-1:0] buf_nx_s;
    logic [2:0]       cnt_nx_s;
    logic [TMO_W-1:0] tmo_nx_s;
    logic [PIN_W-1:0] atmpt_nx_s;
    logic             try_nx_s;
    logic             err_nx_s;
    logic             tout_nx_s;

    logic [1:0]       base_state_s;
    logic [PIN_W-1:0] base_buf_s;
    logic [2:0]       base_cnt_s;

    logic             in_active_s;
    logic             key_valid_s;
    logic             key_clear_s;
    logic             key_enter_s;
    logic             key_digit_s;
    logic             tmo_run_s;
    logic             expire_s;

    key_debounce #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clk          (clk),
        .rst          (rst),
        .key_press    (key_press),
        .key_code_raw (key_code),
        .key_accept   (key_accept_s),
        .key_code     (key_code_s)
    );

    assign in_active_s = (state_r == ST_COLLECT) || (state_r == ST_READY);
    assign key_valid_s = key_accept_s && (key_code_s <= KEY_ENTER);
    assign key_clear_s = key_valid_s && (key_code_s == KEY_CLEAR);
    assign key_enter_s = key_valid_s && (key_code_s == KEY_ENTER);
    assign key_digit_s = key_valid_s && (key_code_s <= KEY_DIGIT_MAX);
    assign tmo_run_s   = in_active_s && (cnt_r != 3'd0);
    assign expire_s    = tmo_run_s && (tmo_r == TMO_MAX);

    // Next-state logic; priority is entry_en drop, CLEAR, ENTER, timeout, digit
    always_comb begin
        state_nx_s   = state_r;
        buf_nx_s     = buf_r;
        cnt_nx_s     = cnt_r;
        tmo_nx_s     = tmo_r;
        atmpt_nx_s   = atmpt_r;
        try_nx_s     = 1'b0;
        err_nx_s     = 1'b0;
        tout_nx_s    = 1'b0;
        base_state_s = state_r;
        base_buf_s   = buf_r;
        base_cnt_s   = cnt_r;

        if (!entry_en) begin
            state_nx_s = ST_IDLE;
            buf_nx_s   = {PIN_W{1'b0}};
            cnt_nx_s   = 3'd0;
            tmo_nx_s   = {TMO_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nx_s = ST_COLLECT;
                    buf_nx_s   = {PIN_W{1'b0}};
                    cnt_nx_s   = 3'd0;
                    tmo_nx_s   = {TMO_W{1'b0}};
                end
                ST_COLLECT, ST_READY, ST_SUBMIT: begin
                    if (key_clear_s) begin
                        state_nx_s = ST_COLLECT;
                        buf_nx_s   = {PIN_W{1'b0}};
                        cnt_nx_s   = 3'd0;
                        tmo_nx_s   = {TMO_W{1'b0}};
                    end else if (key_enter_s) begin
                        tmo_nx_s = {TMO_W{1'b0}};
                        if (state_r == ST_READY) begin
                            // Buffer is kept one more cycle and cleared in SUBMIT
                            atmpt_nx_s = buf_r;
                            try_nx_s   = 1'b1;
                            state_nx_s = ST_SUBMIT;
                        end else begin
                            err_nx_s   = 1'b1;
                            state_nx_s = ST_COLLECT;
                            buf_nx_s   = {PIN_W{1'b0}};
                            cnt_nx_s   = 3'd0;
                        end
                    end else begin
                        // SUBMIT behaves as an empty COLLECT for any key arriving in it
                        if (state_r == ST_SUBMIT) begin
                            base_state_s = ST_COLLECT;
                            base_buf_s   = {PIN_W{1'b0}};
                            base_cnt_s   = 3'd0;
                        end else begin
                            base_state_s = state_r;
                            base_buf_s   = buf_r;
                            base_cnt_s   = cnt_r;
                        end

                        // Expiry wipes the buffer first, so a coincident digit starts a fresh entry
                        if (expire_s) begin
                            tout_nx_s    = 1'b1;
                            base_state_s = ST_COLLECT;
                            base_buf_s   = {PIN_W{1'b0}};
                            base_cnt_s   = 3'd0;
                            tmo_nx_s     = {TMO_W{1'b0}};
                        end else if (tmo_run_s) begin
                            if (tmo_r < TMO_MAX) begin
                                tmo_nx_s = tmo_r + TMO_W'(1);
                            end else begin
                                tmo_nx_s = tmo_r;
                            end
                        end else begin
                            tmo_nx_s = {TMO_W{1'b0}};
                        end

                        if (key_digit_s) begin
                            tmo_nx_s = {TMO_W{1'b0}};
                            if (base_state_s == ST_COLLECT) begin
                                buf_nx_s = {base_buf_s[PIN_W-5:0], key_code_s};
                                cnt_nx_s = base_cnt_s + 3'd1;
                                if ((base_cnt_s + 3'd1) >= DIG_MAX) begin
                                    state_nx_s = ST_READY;
                                end else begin
                                    state_nx_s = ST_COLLECT;
                                end
                            end else begin
                                state_nx_s = base_state_s;
                                buf_nx_s   = base_buf_s;
                                cnt_nx_s   = base_cnt_s;
                            end
                        end else begin
                            state_nx_s = base_state_s;
                            buf_nx_s   = base_buf_s;
                            cnt_nx_s   = base_cnt_s;
                        end
                    end
                end
                default: begin
                    state_nx_s = ST_IDLE;
                    buf_nx_s   = {PIN_W{1'b0}};
                    cnt_nx_s   = 3'd0;
                    tmo_nx_s   = {TMO_W{1'b0}};
                end
            endcase
        end
    end

    // State, buffer, timer and registered output update
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r <= ST_IDLE;
            buf_r   <= {PIN_W{1'b0}};
            cnt_r   <= 3'd0;
            tmo_r   <= {TMO_W{1'b0}};
            atmpt_r <= {PIN_W{1'b0}};
            try_r   <= 1'b0;
            err_r   <= 1'b0;
            tout_r  <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            buf_r   <= buf_nx_s;
            cnt_r   <= cnt_nx_s;
            tmo_r   <= tmo_nx_s;
            atmpt_r <= atmpt_nx_s;
            try_r   <= try_nx_s;
            err_r   <= err_nx_s;
            tout_r  <= tout_nx_s;
        end
    end

    assign psswrd_atmpt  = atmpt_r;
    assign try_psswrd    = try_r;
    assign digit_count   = cnt_r;
    assign entry_timeout = tout_r;
    assign entry_error   = err_r;

endmodule

// File: tb/tb_keypad_pin_entry.sv
// Scoreboard bench for keypad_pin_entry: stimulus pushes expected pulses,
// a monitor pops and compares them whenever a pulse appears.
module tb_keypad_pin_entry;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       entry_en = 1'b0;
    logic       key_press = 1'b0;
    logic [3:0] key_code = 4'h0;
    logic [7:0] psswrd_atmpt;
    logic       try_psswrd;
    logic [2:0] digit_count;
    logic       entry_timeout;
    logic       entry_error;

    int errors = 0;
    int checks = 0;

    // kind: 0 = try_psswrd, 1 = entry_error, 2 = entry_timeout
    typedef struct {
        int         kind;
        logic [7:0] pin;
    } ev_t;

    ev_t exp_q[$];

    keypad_pin_entry dut (
        .clk           (clk),
        .rst           (rst),
        .entry_en      (entry_en),
        .key_press     (key_press),
        .key_code      (key_code),
        .psswrd_atmpt  (psswrd_atmpt),
        .try_psswrd    (try_psswrd),
        .digit_count   (digit_count),
        .entry_timeout (entry_timeout),
        .entry_error   (entry_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    task automatic expect_ev(input int kind, input logic [7:0] pin);
        ev_t e;
        e.kind = kind;
        e.pin  = pin;
        exp_q.push_back(e);
    endtask

    task automatic wait_drain(input string name, input int max_cyc);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < max_cyc) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s: %0d expected pulse(s) still pending after %0d cycles, expected 0",
                     name, exp_q.size(), max_cyc);
            exp_q.delete();
        end
    endtask

    // Clean press: held 10 cycles, then released for 10 cycles
    task automatic press(input logic [3:0] code);
        @(posedge clk);
        #1;
        key_code  = code;
        key_press = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        key_press = 1'b0;
        repeat (10) @(posedge clk);
    endtask

    // Monitor: every output pulse must match the head of the expectation queue
    initial begin
        ev_t e;
        int  k;
        int  n_hi;
        forever begin
            @(negedge clk);
            n_hi = int'(try_psswrd) + int'(entry_error) + int'(entry_timeout);
            if (n_hi != 0) begin
                k = try_psswrd ? 0 : (entry_error ? 1 : 2);
                checks++;
                if (n_hi > 1) begin
                    errors++;
                    $display("FAIL pulse_exclusive: got %0d pulses high, expected at most 1", n_hi);
                end else if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse: got kind %0d pin %0h, expected no pulse", k, psswrd_atmpt);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind != k || e.pin !== psswrd_atmpt) begin
                        errors++;
                        $display("FAIL pulse_match: got kind %0d pin %0h, expected kind %0d pin %0h",
                                 k, psswrd_atmpt, e.kind, e.pin);
                    end
                end
            end
        end
    end

    initial begin
        // Reset state
        #1;
        check("rst_atmpt", 32'(psswrd_atmpt), 32'h00);
        check("rst_try",   32'(try_psswrd),   32'h0);
        check("rst_count", 32'(digit_count),  32'h0);
        check("rst_tout",  32'(entry_timeout), 32'h0);
        check("rst_err",   32'(entry_error),  32'h0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        entry_en = 1'b1;
        repeat (3) @(posedge clk);

        // 1: 5,7,ENTER -> 8'h57
        press(4'd5);
        press(4'd7);
        @(negedge clk);
        check("t1_count2", 32'(digit_count), 32'd2);
        expect_ev(0, 8'h57);
        press(4'hB);
        wait_drain("t1_submit", 10);
        @(negedge clk);
        check("t1_count0", 32'(digit_count), 32'd0);
        check("t1_atmpt",  32'(psswrd_atmpt), 32'h57);

        // 2: bouncing 5 then held -> one digit
        @(posedge clk);
        #1;
        key_code = 4'd5;
        for (int i = 0; i < 3; i++) begin
            key_press = 1'b1;
            @(posedge clk);
            #1;
            key_press = 1'b0;
            @(posedge clk);
            #1;
        end
        key_press = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        key_press = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("t2_bounce_count", 32'(digit_count), 32'd1);
        press(4'hA);
        @(negedge clk);
        check("t2_clear_count", 32'(digit_count), 32'd0);

        // 3: 5,CLEAR,1,2,ENTER -> 8'h12; then 5,ENTER -> error, PIN held
        press(4'd5);
        press(4'hA);
        press(4'hD);
        press(4'd1);
        press(4'd2);
        @(negedge clk);
        check("t3_count2", 32'(digit_count), 32'd2);
        expect_ev(0, 8'h12);
        press(4'hB);
        wait_drain("t3_submit", 10);
        press(4'd5);
        expect_ev(1, 8'h12);
        press(4'hB);
        wait_drain("t3_error", 10);
        @(negedge clk);
        check("t3_err_count", 32'(digit_count), 32'd0);
        check("t3_atmpt_held", 32'(psswrd_atmpt), 32'h12);

        // 4: press 3, then idle -> timeout
        @(posedge clk);
        #1;
        key_code  = 4'd3;
        key_press = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        key_press = 1'b0;
        repeat (52) @(posedge clk);
        @(negedge clk);
        check("t4_count_before", 32'(digit_count), 32'd1);
        repeat (6) @(posedge clk);
        expect_ev(2, 8'h12);
        wait_drain("t4_timeout", 30);
        @(negedge clk);
        check("t4_count_after", 32'(digit_count), 32'd0);

        // 5: 5,7 then entry_en drops in the ENTER accept cycle
        press(4'd5);
        press(4'd7);
        @(posedge clk);
        #1;
        key_code  = 4'hB;
        key_press = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        entry_en = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        key_press = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("t5_idle_count", 32'(digit_count), 32'd0);
        check("t5_atmpt_held", 32'(psswrd_atmpt), 32'h12);
        entry_en = 1'b1;
        repeat (3) @(posedge clk);
        press(4'd9);
        press(4'd9);
        expect_ev(0, 8'h99);
        press(4'hB);
        wait_drain("t5_submit", 10);

        // 6: asynchronous reset mid-entry
        press(4'd5);
        @(negedge clk);
        check("t6_count1", 32'(digit_count), 32'd1);
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check("t6_rst_atmpt", 32'(psswrd_atmpt), 32'h00);
        check("t6_rst_count", 32'(digit_count), 32'd0);
        check("t6_rst_try",   32'(try_psswrd), 32'h0);
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        press(4'd5);
        press(4'd7);
        expect_ev(0, 8'h57);
        press(4'hB);
        wait_drain("t6_submit", 10);
        @(negedge clk);
        check("t6_atmpt", 32'(psswrd_atmpt), 32'h57);

        repeat (5) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
